// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage built as a 2-entry valid/ready skid buffer.
// The head register (H) drives decode. The skid register (S) catches a beat
// accepted while decode is not taking H. Every output comes from registers
// or from a decode of the registered state, so no path runs from in_* to out_*.
module ifid_skid_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000),
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic                  in_fault,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic                  out_fault,
    input  logic                  stall,
    input  logic                  flush,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;

    logic [ADDR_WIDTH-1:0] h_pc_q, h_pc_d;
    logic [DATA_WIDTH-1:0] h_instr_q, h_instr_d;
    logic                  h_fault_q, h_fault_d;
    logic [ADDR_WIDTH-1:0] s_pc_q, s_pc_d;
    logic [DATA_WIDTH-1:0] s_instr_q, s_instr_d;
    logic                  s_fault_q, s_fault_d;

    logic                  acc;
    logic                  deq;

    // Handshake decode: in_ready depends only on the registered state.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign acc       = in_valid & in_ready;
    assign deq       = out_valid & out_ready & ~stall;

    // Next-state and register-load selection. The input fields are only
    // sampled on an accept, so idle-bus garbage never reaches H or S.
    // A flush drops everything, including a beat accepted this cycle,
    // and leaves the head PC as it was.
    always_comb begin
        state_d   = state_q;
        h_pc_d    = h_pc_q;
        h_instr_d = h_instr_q;
        h_fault_d = h_fault_q;
        s_pc_d    = s_pc_q;
        s_instr_d = s_instr_q;
        s_fault_d = s_fault_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        h_pc_d    = in_pc;
                        h_instr_d = in_instr;
                        h_fault_d = in_fault;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (acc && deq) begin
                        h_pc_d    = in_pc;
                        h_instr_d = in_instr;
                        h_fault_d = in_fault;
                    end else if (acc) begin
                        s_pc_d    = in_pc;
                        s_instr_d = in_instr;
                        s_fault_d = in_fault;
                        state_d   = FULL;
                    end else if (deq) begin
                        state_d   = EMPTY;
                    end
                end
                FULL: begin
                    // S always drains into H; it is never bypassed.
                    if (deq) begin
                        h_pc_d    = s_pc_q;
                        h_instr_d = s_instr_q;
                        h_fault_d = s_fault_q;
                        state_d   = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // FSM state register; reset wins over flush, stall and handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head PC register; reset restores the boot PC seen by decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_pc_q <= RESET_PC;
        end else begin
            h_pc_q <= h_pc_d;
        end
    end

    // Payload registers; their contents are masked by state while invalid.
    always_ff @(posedge clk) begin
        h_instr_q <= h_instr_d;
        h_fault_q <= h_fault_d;
        s_pc_q    <= s_pc_d;
        s_instr_q <= s_instr_d;
        s_fault_q <= s_fault_d;
    end

    // Output decode: bubble NOP and cleared fault whenever the head is empty.
    always_comb begin
        out_pc    = h_pc_q;
        out_instr = out_valid ? h_instr_q : NOP_INSTR;
        out_fault = out_valid & h_fault_q;
        case (state_q)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Bench for ifid_skid_stage: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the stage.
module tb_ifid_skid_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_fault;
    logic [31:0] in_pc, in_instr;
    logic        out_valid, out_ready, out_fault, stall, flush;
    logic [31:0] out_pc, out_instr;
    logic [1:0]  occupancy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } beat_t;

    beat_t       mq[$];
    logic [31:0] m_last_pc;

    ifid_skid_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_fault(in_fault),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault),
        .stall(stall), .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all DUT outputs with the model state.
    task automatic compare_model();
        int n;
        n = mq.size();
        chk("occupancy", 32'(occupancy), 32'(n));
        chk("out_valid", 32'(out_valid), 32'(n > 0));
        chk("in_ready",  32'(in_ready),  32'(n < 2));
        chk("out_pc",    out_pc,    (n > 0) ? mq[0].pc : m_last_pc);
        chk("out_instr", out_instr, (n > 0) ? mq[0].instr : NOP);
        chk("out_fault", 32'(out_fault), (n > 0) ? 32'(mq[0].fault) : 32'd0);
    endtask

    // One clock: model follows the same inputs the DUT sampled, then compare.
    task automatic step();
        bit    a, d;
        beat_t b;
        @(posedge clk);
        a = in_valid && (mq.size() < 2);
        d = (mq.size() > 0) && out_ready && !stall;
        if (reset) begin
            mq.delete();
            m_last_pc = RST_PC;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (d) void'(mq.pop_front());
            if (a) begin
                b.pc = in_pc; b.instr = in_instr; b.fault = in_fault;
                mq.push_back(b);
            end
        end
        if (mq.size() > 0) m_last_pc = mq[0].pc;
        #1;
        compare_model();
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic f);
        in_valid = v; in_pc = pc; in_instr = ins; in_fault = f;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; stall = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        m_last_pc = RST_PC;
        step();
        reset = 1'b0;
        // Reset values pinned with literals.
        chk("rst_pc", out_pc, 32'h8000_0000);
        chk("rst_instr", out_instr, 32'h0000_0013);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Streaming with out_ready=1: each beat visible one cycle later.
        out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 32'h0000_0093, 1'b0); step();
        chk("s0_pc", out_pc, 32'h8000_0000);
        drive(1'b1, 32'h8000_0004, 32'h0010_0113, 1'b0); step();
        chk("s1_instr", out_instr, 32'h0010_0113);
        drive(1'b1, 32'h8000_0008, 32'h0020_0193, 1'b0); step();
        chk("s2_pc", out_pc, 32'h8000_0008);
        chk("s2_occ", 32'(occupancy), 32'd1);
        drive(1'b0, 32'hdead_beef, 32'hdead_beef, 1'b1); step();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_pc", out_pc, 32'h8000_0008);

        // Backpressure: fill, third beat held off, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0000, 32'h0000_0093, 1'b0); step();
        drive(1'b1, 32'h8000_0004, 32'h0010_0113, 1'b0); step();
        chk("bp_occ", 32'(occupancy), 32'd2);
        chk("bp_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h8000_0008, 32'h0020_0193, 1'b0); step();
        chk("bp_head", out_pc, 32'h8000_0000);
        out_ready = 1'b1; step();
        chk("bp_pc1", out_pc, 32'h8000_0004);
        step();
        chk("bp_pc2", out_pc, 32'h8000_0008);
        drive(1'b0, 32'h0, 32'h0, 1'b0); step();

        // Stall in FULL holds everything even with out_ready=1.
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0010, 32'h0000_0001, 1'b1); step();
        drive(1'b1, 32'h8000_0014, 32'h0000_0002, 1'b0); step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("fault_head", 32'(out_fault), 32'd1);
        stall = 1'b1; out_ready = 1'b1;
        repeat (4) step();
        chk("stall_occ", 32'(occupancy), 32'd2);
        chk("stall_pc", out_pc, 32'h8000_0010);
        stall = 1'b0; step();
        chk("unstall_occ", 32'(occupancy), 32'd1);
        chk("fault_next", 32'(out_fault), 32'd0);

        // Flush while FULL with a beat offered: it must never appear.
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0018, 32'h0000_0003, 1'b0); step();
        drive(1'b1, 32'h8000_001c, 32'h0000_0004, 1'b1); flush = 1'b1; step();
        flush = 1'b0; drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_instr", out_instr, 32'h0000_0013);
        chk("fl_fault", 32'(out_fault), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        chk("fl_pc", out_pc, 32'h8000_0014);

        // Reset together with flush while FULL, then resume streaming.
        drive(1'b1, 32'h8000_0020, 32'h0000_0005, 1'b0); step();
        drive(1'b1, 32'h8000_0024, 32'h0000_0006, 1'b0); step();
        reset = 1'b1; flush = 1'b1; step();
        reset = 1'b0; flush = 1'b0;
        chk("rf_pc", out_pc, 32'h8000_0000);
        chk("rf_occ", 32'(occupancy), 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'h8000_0030, 32'h0000_0007, 1'b0); step();
        chk("rf_resume", out_pc, 32'h8000_0030);

        // Randomized traffic; idle cycles carry junk payload.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pc     = $urandom;
            in_instr  = $urandom;
            in_fault  = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            stall     = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            reset     = ($urandom_range(0, 200) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifid_skid_stage.md
Name: ifid_skid_stage

Overview:
- Parametrised IF/ID pipeline stage. Replaces the plain stall/flush register with a valid/ready-handshaked, 2-entry skid buffer.
- Sits between fetch (PC register plus instruction memory response) and decode.
- Carries PC, instruction and fetch-fault per beat, preserving order.
- Supports external stall, synchronous flush and NOP bubble insertion, so decode never sees stale instructions.

Parameters:
- ADDR_WIDTH, 32, width of PC field.
- DATA_WIDTH, 32, width of instruction field.
- RESET_PC, 32'h8000_0000, value driven on out_pc after reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on out_instr whenever out_valid=0 (bubble).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  fetch presents a beat
- in_ready  output  1  stage can accept a beat this cycle
- in_pc  input  ADDR_WIDTH  PC of incoming beat
- in_instr  input  DATA_WIDTH  instruction of incoming beat
- in_fault  input  1  fetch fault flag of incoming beat
- out_valid  output  1  beat available to decode
- out_ready  input  1  decode can take the beat
- out_pc  output  ADDR_WIDTH  PC of head beat
- out_instr  output  DATA_WIDTH  instruction of head beat, or NOP_INSTR when empty
- out_fault  output  1  fault flag of head beat, 0 when empty
- stall  input  1  hazard stall from decode/hazard unit; blocks output transfer
- flush  input  1  kill all buffered beats (branch/exception redirect)
- occupancy  output  2  number of valid beats held (0..2)

Behaviour:
- Reset: one clock, synchronous, active-high. Clock is clk, reset is reset.
  - Values after a reset edge: state EMPTY, occupancy=0, out_valid=0, out_pc=RESET_PC, out_instr=NOP_INSTR, out_fault=0, in_ready=1.
  - Reset overrides flush, stall and all handshakes in the same cycle.
- Storage: head register H (drives outputs) and skid register S. Every output is a register or a decode of state; no combinational path from in_* to out_*.
- States:
  - EMPTY: H invalid, S invalid.
  - ONE: H valid, S invalid.
  - FULL: H valid, S valid.
  - occupancy = 0/1/2 respectively.
- Handshakes:
  - in_ready = (state != FULL), a function of registered state only.
  - Accept event A = in_valid & in_ready.
  - Output event D = out_valid & out_ready & ~stall. stall=1 holds H and S unchanged regardless of out_ready.
- Transitions (flush=0):
  - EMPTY: A -> load H from inputs, go to ONE. Otherwise stay.
  - ONE: A&D -> load H from inputs, stay ONE. A&~D -> load S, go to FULL. ~A&D -> go to EMPTY. Neither -> hold.
  - FULL: D -> move S to H, go to ONE (A impossible since in_ready=0). ~D -> hold.
- Ordering: beats leave in acceptance order. S is never bypassed.
- Flush:
  - flush=1 (reset=0) -> next state EMPTY, occupancy=0, out_valid=0, out_instr=NOP_INSTR, out_fault=0.
  - A beat accepted in the flush cycle is discarded; in_ready stays as state dictates.
  - A D event in the flush cycle still counts as consumed by decode.
  - flush overrides stall.
  - out_pc retains the last head PC (not cleared) after flush.
- Empty outputs: whenever out_valid=0, out_instr=NOP_INSTR and out_fault=0. out_pc holds its last value (RESET_PC after reset).
- Throughput: 1 beat/cycle sustained when out_ready=1 and stall=0. Latency in_valid -> out_valid is 1 cycle.
- Widths: fields copied verbatim; no arithmetic on PC. Parameters are independent; any ADDR_WIDTH/DATA_WIDTH >= 1 is legal.
- X-safety: in_pc/in_instr/in_fault are sampled only on A. Values when in_valid=0 never propagate.

Test Plan:
- Reset then stream PC 0x8000_0000/04/08, instr 0x0000_0093/0x0010_0113/0x0020_0193, out_ready=1 -> each appears one cycle later, out_valid continuous, occupancy=1, in_ready=1 throughout.
- Stream 3 beats with out_ready=0 -> occupancy 1 then 2, in_ready=0 after 2nd accept, 3rd beat held off. Raise out_ready -> beats exit in order 0x8000_0000, 0x8000_0004, then 0x8000_0008 accepted.
- FULL, stall=1, out_ready=1 for 4 cycles -> outputs and occupancy unchanged. Drop stall -> head transfers, occupancy 2 -> 1.
- FULL plus flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_instr=0x0000_0013, out_fault=0, in_ready=1. Incoming beat never appears.
- in_fault=1 on PC 0x8000_0010 -> out_fault=1 only while that beat is head; 0 when empty or for other beats.
- Assert reset mid-stream with occupancy=2 and flush=1 simultaneously -> next cycle out_pc=0x8000_0000, out_valid=0, occupancy=0. Resumes normal streaming the following cycle.
